// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the I-cache and D-cache refill engines.
// One word transaction at a time; aborts a memory access that never completes.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [2:0]            m0_ctrl,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ready,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [2:0]            m1_ctrl,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {StIdle, StGrant0, StGrant1, StDone0, StDone1} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT - 1);

    state_e                state_q;
    logic                  last_grant_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  mem_req_q, mem_we_q;
    logic [2:0]            mem_ctrl_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
    logic                  m0_ready_q, m1_ready_q;
    logic                  grant_id_q, busy_q, timeout_err_q;

    logic                  pick1;
    logic                  finish;
    logic [DATA_WIDTH-1:0] cap_data;

    // On a tie the requester that did not own the last transaction wins.
    always_comb begin
        pick1 = m1_req;
        if (m0_req && m1_req) begin
            pick1 = ~last_grant_q;
        end
    end

    assign finish   = mem_ready || (cnt_q == CntMax);
    assign cap_data = mem_ready ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_ctrl_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            m0_ready_q    <= 1'b0;
            m1_ready_q    <= 1'b0;
            grant_id_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (m0_req || m1_req) begin
                        state_q     <= pick1 ? StGrant1 : StGrant0;
                        grant_id_q  <= pick1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= pick1 ? m1_we    : m0_we;
                        mem_ctrl_q  <= pick1 ? m1_ctrl  : m0_ctrl;
                        mem_addr_q  <= pick1 ? m1_addr  : m0_addr;
                        mem_wdata_q <= pick1 ? m1_wdata : m0_wdata;
                    end
                end
                StGrant0, StGrant1: begin
                    if (finish) begin
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_ctrl_q  <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (!mem_ready) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (state_q == StGrant0) begin
                            state_q    <= StDone0;
                            m0_rdata_q <= cap_data;
                            m0_ready_q <= 1'b1;
                        end else begin
                            state_q    <= StDone1;
                            m1_rdata_q <= cap_data;
                            m1_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone0: begin
                    state_q      <= StIdle;
                    last_grant_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                StDone1: begin
                    state_q      <= StIdle;
                    last_grant_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_ctrl    = mem_ctrl_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between two cache controllers: requester 0 (instruction-cache refill) and requester 1 (data-cache refill/write-back).
- Each requester issues one word-level transaction at a time, using a req/ready handshake.
- The arbiter picks a winner by round-robin, registers the request, and drives the memory-side handshake.
- It returns read data with a one-cycle completion pulse, and aborts transactions that exceed a timeout.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT, 64, maximum cycles in a GRANT state waiting for mem_ready before abort; must be ≥ 2
- CNT_WIDTH, 7, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- m0_req  in  1  requester 0 transaction request (level)
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_ctrl  in  3  requester 0 access mode, passed to memory unchanged
- m0_addr  in  ADDR_WIDTH  requester 0 address
- m0_wdata  in  DATA_WIDTH  requester 0 write data
- m0_rdata  out  DATA_WIDTH  requester 0 read data, valid while m0_ready=1
- m0_ready  out  1  requester 0 completion pulse
- m1_req, m1_we, m1_ctrl, m1_addr, m1_wdata, m1_rdata, m1_ready  same as m0_*, for requester 1
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_ctrl  out  3  memory access mode
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion (may be high in the same cycle as mem_req)
- grant_id  out  1  owner of the current or last transaction
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky flag, set on abort, cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clock edge, taking priority over everything):
  - State → IDLE; all outputs → 0; last_grant → 1, so requester 0 wins the first tie.
  - A reset mid-transaction drops mem_req the next cycle. No ready pulse is issued.
- States: IDLE, GRANT0, GRANT1, DONE0, DONE1.
- IDLE:
  - If only mx_req=1: latch mx_we/ctrl/addr/wdata into registers, go to GRANTx, set grant_id=x.
  - If both requests are high: the winner is the requester not equal to last_grant.
  - If neither is high: stay in IDLE.
- GRANTx:
  - mem_req=1; mem_* driven from the latched registers, which stay stable for the whole state.
  - Timeout counter increments each cycle.
  - On mem_ready=1: capture mem_rdata, clear the counter, go to DONEx.
  - If the counter reaches TIMEOUT-1 without mem_ready: set timeout_err, captured data=0, go to DONEx.
- DONEx:
  - mx_ready=1 and mx_rdata=captured data for exactly one cycle; mem_req=0.
  - last_grant ← x; next state is IDLE.
  - m(1-x)_ready stays 0.
- Requester contract:
  - Hold mx_req and its fields stable until mx_ready is sampled high.
  - Deassert mx_req at that same edge.
  - The arbiter does not sample requests in DONE states.
  - Requests that arrive during GRANT/DONE wait; none are lost while held high.
- Latency: req sampled at edge E → mem_req high from E+1.
  - If mem_ready arrives in cycle k, mx_ready is high in cycle k+1.
  - With zero-wait memory, mx_ready is high 2 cycles after E.
- Write transactions also pulse mx_ready. mx_rdata is don't-care for writes but is driven from the captured mem_rdata.
- mem_* fields are 0 outside GRANT states. mx_rdata holds its value between pulses.
- Fairness: back-to-back contention alternates strictly 0,1,0,1. No requester waits more than one transaction.

Test Plan:
- Single read: m0_req, addr=0x100; memory returns 0xDEADBEEF with 3 wait cycles → mem_addr=0x100 for 4 cycles, one m0_ready pulse with m0_rdata=0xDEADBEEF, m1_ready never asserted.
- Contention after reset: m0_req and m1_req both high at the same edge → requester 0 served first. Both stay high → order 0,1,0,1 over 4 transactions, grant_id matches the order.
- Write-back then refill: m1 write addr=0x40, wdata=0x12345678, followed immediately by m1 read 0x80; m0 idle → mem_we=1 then 0, addresses 0x40 then 0x80, two m1_ready pulses.
- Zero-wait memory: mem_ready tied high → m0_ready occurs 2 cycles after req is sampled. busy=1 for exactly 2 cycles per transaction.
- Timeout: mem_ready held low, TIMEOUT=8 → mem_req high for 8 cycles, then m0_ready with m0_rdata=0, timeout_err=1 and remaining 1 after later normal transactions.
- Reset mid-GRANT1: assert rst_n=0 for one cycle during wait → next cycle mem_req=0, busy=0, no m1_ready. After release, m1 (still requesting) is re-served fully.
